mcr2_rom_arbiter: RTL and testbench
===================================

Name: mcr2_rom_arbiter

Overview:
- Shares the single-port 64 KB program/sound ROM RAM between three requesters:
  - the HPS download writer;
  - the main Z80 fetch port;
  - the sound Z80 fetch port.
- Sits between the top-level download logic, the mcr2 core's cpu_rom/snd_rom ports, and one synchronous-read RAM.
- Replaces the dual-port ROM instance so the design fits single-port block RAM.

Parameters:
- AW, 16, full ROM address width.
- SND_AW, 14, sound port address width.
- SND_BASE, 2'b11, upper AW-SND_AW address bits prepended to snd_addr.

Ports:
- clk_sys  in  1  system clock (40 MHz).
- reset  in  1  asynchronous, active-high reset.
- dl_active  in  1  ROM download in progress; blocks all read grants.
- dl_wr  in  1  download write strobe, one cycle per byte.
- dl_addr  in  AW  download byte address.
- dl_data  in  8  download byte.
- cpu_req  in  1  main CPU read request, level.
- cpu_addr  in  AW  main CPU read address.
- cpu_ack  out  1  one-cycle pulse: cpu_data valid.
- cpu_data  out  8  main CPU read data, held until next cpu_ack.
- snd_req  in  1  sound CPU read request, level.
- snd_addr  in  SND_AW  sound CPU read address.
- snd_ack  out  1  one-cycle pulse: snd_data valid.
- snd_data  out  8  sound read data, held until next snd_ack.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_d  out  8  RAM write data.
- mem_q  in  8  RAM read data, valid one cycle after address.

Behaviour:
- Reset (async, asserted): state IDLE.
  - cpu_ack=0, snd_ack=0, cpu_data=0, snd_data=0.
  - mem_we=0, mem_addr=0, mem_d=0.
  - last_grant=SND, so CPU wins first tie.
- Reset mid-access: in-flight read is dropped, no ack issued, and the requester's req is re-arbitrated after release.
- FSM states: IDLE, RD_CPU, RD_SND.
- Write priority:
  - Any cycle with dl_wr=1 drives combinationally mem_we=1, mem_addr=dl_addr, mem_d=dl_data, regardless of state.
  - A read issue wanted in that cycle is deferred; FSM stays IDLE.
  - A write in RD_* state is legal; mem_q for the pending read is unaffected (registered output).
- IDLE:
  - If dl_active=1 or dl_wr=1: no grant.
  - Else if exactly one req is high: grant it.
  - Else if both are high: grant the requester != last_grant (round robin).
  - On grant: drive mem_addr. For CPU it is cpu_addr; for sound it is {SND_BASE, snd_addr}. Update last_grant and go to RD_CPU or RD_SND.
- RD_x:
  - Register mem_q into x_data.
  - Pulse x_ack for one cycle (registered, visible the next cycle).
  - Return to IDLE.
- Latency: req high in cycle N with port free → ack high in cycle N+2, data valid the same cycle.
- Throughput: one read per 2 cycles. Under continuous contention the ports alternate: CPU, SND, CPU…
- Requester holds req and addr stable until ack. A req still high in the cycle after ack is treated as a new request.
- Address changed while not granted: the value sampled at grant is used.
- dl_active falling edge: arbitration resumes the next cycle; no stale ack is emitted.
- Both acks are never high in the same cycle.

Optional Feature:
- Macro: MCR2_ROM_ARB_CACHE_EN.
- Enabled:
  - Each read port keeps a one-entry tag (last address + data + valid).
  - In IDLE, a req whose address equals a valid tag pulses ack in the next cycle (latency 1) with the cached data, with no RAM access and no change to last_grant.
  - A hit on one port does not block a miss grant to the other port in the same cycle.
  - All tags are invalidated on reset, on any dl_wr, and while dl_active=1.
- Disabled: no tags; every read takes the 2-cycle RAM path.

Test Plan:
- Reset release, cpu_req=1, cpu_addr=16'h0123, RAM[0123]=8'hA5 → cpu_ack pulse exactly 2 cycles later, cpu_data=8'hA5, mem_we=0 throughout.
- cpu_req and snd_req both held high, snd_addr=14'h0010, RAM[C010]=8'h3C → acks alternate CPU first then SND, mem_addr for the sound read = 16'hC010, snd_data=8'h3C, never both acks in one cycle.
- dl_active=1, 256 dl_wr strobes to 0000..00FF with data=addr[7:0], cpu_req=1 throughout → no cpu_ack during download; after dl_active falls, the read of 16'h0042 returns 8'h42.
- dl_wr asserted in the same cycle IDLE would grant the CPU → write to dl_addr happens that cycle, CPU grant delayed one cycle, cpu_ack at N+3 with correct data.
- reset pulsed during RD_SND → snd_ack stays 0, outputs return to 0; after release the held snd_req is acked with correct data.
- With MCR2_ROM_ARB_CACHE_EN:
  - a second cpu read of the same address → ack after 1 cycle, no mem_addr change;
  - after an intervening dl_wr, the same address takes 2 cycles and returns the new data.

Source files
------------

// File: rtl/mcr2_rom_arbiter.sv
// mcr2_rom_arbiter
// ----------------
// Shares one single-port, synchronous-read 64 KB ROM RAM between three users:
// the HPS download writer, the main Z80 fetch port and the sound Z80 fetch
// port. Download writes always win and go straight to the RAM in the cycle
// they are strobed. Reads are issued from IDLE. The RAM returns data one
// cycle later (RD_CPU / RD_SND), and that data is registered into the
// requester's data output together with a one-cycle ack.
//
// Ports:
//   clk_sys, reset              system clock, asynchronous active-high reset
//   dl_active                   download in progress (blocks every read grant)
//   dl_wr, dl_addr, dl_data     download byte write strobe / address / data
//   cpu_req, cpu_addr           main CPU level request and address
//   cpu_ack, cpu_data           one-cycle ack pulse and held read data
//   snd_req, snd_addr           sound CPU level request and short address
//   snd_ack, snd_data           one-cycle ack pulse and held read data
//   mem_addr, mem_we, mem_d     RAM address / write enable / write data
//   mem_q                       RAM read data (valid one cycle after address)
//
// Optional build macro MCR2_ROM_ARB_CACHE_EN adds a one-entry tag per read
// port. A repeat read of the last address is answered in one cycle without a
// RAM access. Without the macro every read takes the two-cycle RAM path.

module mcr2_rom_arbiter #(
   parameter int AW = 16,
   parameter int SND_AW = 14,
   parameter logic [AW-SND_AW-1:0] SND_BASE = 2'b11
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [AW-1:0]     dl_addr,
   input  logic [7:0]        dl_data,
   input  logic              cpu_req,
   input  logic [AW-1:0]     cpu_addr,
   output logic              cpu_ack,
   output logic [7:0]        cpu_data,
   input  logic              snd_req,
   input  logic [SND_AW-1:0] snd_addr,
   output logic              snd_ack,
   output logic [7:0]        snd_data,
   output logic [AW-1:0]     mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_d,
   input  logic [7:0]        mem_q
);

   typedef enum logic [1:0] {IDLE = 2'd0, RD_CPU = 2'd1, RD_SND = 2'd2} state_t;
   typedef enum logic {PORT_CPU = 1'b0, PORT_SND = 1'b1} port_t;

   state_t        state;
   port_t         last_grant;
   logic [AW-1:0] addr_hold;

   logic [AW-1:0] snd_full;
   logic          arb_open;
   logic          cpu_hit, snd_hit;
   logic          cpu_hit_win, snd_hit_win;
   logic [7:0]    cpu_hit_data, snd_hit_data;
   logic          cpu_want, snd_want;
   logic          grant_cpu, grant_snd;

   // The sound CPU only sees the top 16 KB of the ROM.
   assign snd_full = {SND_BASE, snd_addr};

   // Reads may only be issued from IDLE in a cycle free of download traffic.
   // Reset is included so nothing is granted while reset is held.
   assign arb_open = (state == IDLE) && !dl_active && !dl_wr && !reset;

`ifdef MCR2_ROM_ARB_CACHE_EN
   logic          cpu_tag_valid, snd_tag_valid;
   logic [AW-1:0] cpu_tag_addr, snd_tag_addr;
   logic [7:0]    cpu_tag_data, snd_tag_data;
   port_t         hit_last;

   // Tag lookup. If both ports hit in the same cycle only one can be acked,
   // so they take turns through hit_last. last_grant belongs to the RAM
   // arbitration and is left alone by hits.
   always_comb begin
      cpu_hit      = arb_open && cpu_req && cpu_tag_valid && (cpu_tag_addr == cpu_addr);
      snd_hit      = arb_open && snd_req && snd_tag_valid && (snd_tag_addr == snd_full);
      cpu_hit_win  = cpu_hit && (!snd_hit || (hit_last == PORT_SND));
      snd_hit_win  = snd_hit && !cpu_hit_win;
      cpu_hit_data = cpu_tag_data;
      snd_hit_data = snd_tag_data;
   end

   // Tags are filled from the RAM read in RD_x. Any download activity may
   // change ROM contents, so it drops both tags. Dropping has priority over
   // a fill in the same cycle.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cpu_tag_valid <= 1'b0;
         snd_tag_valid <= 1'b0;
         cpu_tag_addr  <= '0;
         snd_tag_addr  <= '0;
         cpu_tag_data  <= 8'h00;
         snd_tag_data  <= 8'h00;
         hit_last      <= PORT_SND;
      end else begin
         if (dl_wr || dl_active) begin
            cpu_tag_valid <= 1'b0;
            snd_tag_valid <= 1'b0;
         end else begin
            if (state == RD_CPU) begin
               cpu_tag_valid <= 1'b1;
               cpu_tag_addr  <= addr_hold;
               cpu_tag_data  <= mem_q;
            end
            if (state == RD_SND) begin
               snd_tag_valid <= 1'b1;
               snd_tag_addr  <= addr_hold;
               snd_tag_data  <= mem_q;
            end
         end
         if (cpu_hit_win) begin
            hit_last <= PORT_CPU;
         end else if (snd_hit_win) begin
            hit_last <= PORT_SND;
         end
      end
   end
`else
   // No tags: every request goes to the RAM.
   always_comb begin
      cpu_hit      = 1'b0;
      snd_hit      = 1'b0;
      cpu_hit_win  = 1'b0;
      snd_hit_win  = 1'b0;
      cpu_hit_data = 8'h00;
      snd_hit_data = 8'h00;
   end
`endif

   // RAM arbitration among the ports that actually need the RAM. On a tie,
   // the port that did not win last time wins, so the two CPUs alternate.
   always_comb begin
      cpu_want  = arb_open && cpu_req && !cpu_hit;
      snd_want  = arb_open && snd_req && !snd_hit;
      grant_cpu = cpu_want && (!snd_want || (last_grant == PORT_SND));
      grant_snd = snd_want && !grant_cpu;
   end

   // RAM port mux. A download write takes the port in the cycle it is
   // strobed. A read grant drives its address in the grant cycle, so mem_q is
   // ready in the following RD_x cycle. Otherwise the address of the last
   // read is held, which keeps the RAM address quiet between accesses.
   always_comb begin
      mem_we   = 1'b0;
      mem_d    = 8'h00;
      mem_addr = addr_hold;
      if (dl_wr && !reset) begin
         mem_we   = 1'b1;
         mem_addr = dl_addr;
         mem_d    = dl_data;
      end else if (grant_cpu) begin
         mem_addr = cpu_addr;
      end else if (grant_snd) begin
         mem_addr = snd_full;
      end
   end

   // Read sequencer. Acks are registered pulses, so data and ack appear
   // together one cycle after RD_x, or one cycle after a tag hit. A reset
   // during RD_x drops the read. The still-held request is arbitrated again
   // after release.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= PORT_SND;
         addr_hold  <= '0;
         cpu_ack    <= 1'b0;
         snd_ack    <= 1'b0;
         cpu_data   <= 8'h00;
         snd_data   <= 8'h00;
      end else begin
         cpu_ack <= 1'b0;
         snd_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_cpu) begin
                  state      <= RD_CPU;
                  last_grant <= PORT_CPU;
                  addr_hold  <= cpu_addr;
               end else if (grant_snd) begin
                  state      <= RD_SND;
                  last_grant <= PORT_SND;
                  addr_hold  <= snd_full;
               end
               if (cpu_hit_win) begin
                  cpu_ack  <= 1'b1;
                  cpu_data <= cpu_hit_data;
               end
               if (snd_hit_win) begin
                  snd_ack  <= 1'b1;
                  snd_data <= snd_hit_data;
               end
            end
            RD_CPU: begin
               cpu_data <= mem_q;
               cpu_ack  <= 1'b1;
               state    <= IDLE;
            end
            RD_SND: begin
               snd_data <= mem_q;
               snd_ack  <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcr2_rom_arbiter.sv
// tb_mcr2_rom_arbiter
// -------------------
// Bench for mcr2_rom_arbiter. It has a behavioural model of the synchronous
// RAM and a shadow copy of the ROM contents that the bench updates from its
// own download stimulus. A table of single reads comes first, then
// hand-written multi-cycle sequences, then a randomized mix of both CPUs and
// download bursts. In the random phase every ack is scored against the
// shadow memory.

module tb_mcr2_rom_arbiter;

   logic        clk_sys;
   logic        reset;
   logic        dl_active;
   logic        dl_wr;
   logic [15:0] dl_addr;
   logic [7:0]  dl_data;
   logic        cpu_req;
   logic [15:0] cpu_addr;
   logic        cpu_ack;
   logic [7:0]  cpu_data;
   logic        snd_req;
   logic [13:0] snd_addr;
   logic        snd_ack;
   logic [7:0]  snd_data;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_d;
   logic [7:0]  mem_q;

   logic [7:0]  ram [0:65535];
   logic [7:0]  shadow [0:65535];

   int vectors = 0;
   int miscompares = 0;
   logic we_seen;

   typedef struct {
      logic        is_snd;
      logic [15:0] addr;
      logic [7:0]  exp_data;
      string       name;
   } vec_t;

   vec_t vecs [6];

   mcr2_rom_arbiter dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .dl_active(dl_active),
      .dl_wr    (dl_wr),
      .dl_addr  (dl_addr),
      .dl_data  (dl_data),
      .cpu_req  (cpu_req),
      .cpu_addr (cpu_addr),
      .cpu_ack  (cpu_ack),
      .cpu_data (cpu_data),
      .snd_req  (snd_req),
      .snd_addr (snd_addr),
      .snd_ack  (snd_ack),
      .snd_data (snd_data),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_d    (mem_d),
      .mem_q    (mem_q)
   );

   // 40 MHz-style clock (period 10 time units).
   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   // Single-port RAM with one cycle of read latency (read-before-write).
   always @(posedge clk_sys) begin
      if (mem_we) ram[mem_addr] <= mem_d;
      mem_q <= ram[mem_addr];
   end

   // Records any write strobe so a read-only stretch can be checked.
   always @(negedge clk_sys) begin
      if (mem_we) we_seen = 1'b1;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] fill_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      dl_active = 1'b0;
      dl_wr     = 1'b0;
      dl_addr   = '0;
      dl_data   = '0;
      cpu_req   = 1'b0;
      cpu_addr  = '0;
      snd_req   = 1'b0;
      snd_addr  = '0;
      repeat (2) @(posedge clk_sys);
      #1 reset = 1'b0;
   endtask

   // Called at posedge+1 of the request cycle. Returns the number of cycles
   // until the ack is seen (99 on timeout). Drops the request inside the ack
   // cycle and returns at posedge+1 of the following cycle.
   task automatic wait_ack(input logic is_snd, output int lat, output logic [7:0] data);
      bit done;
      lat  = 0;
      data = 8'h00;
      done = 0;
      while (!done) begin
         @(negedge clk_sys);
         if (is_snd ? snd_ack : cpu_ack) begin
            data = is_snd ? snd_data : cpu_data;
            done = 1;
         end else if (lat >= 20) begin
            lat  = 99;
            done = 1;
         end else begin
            @(posedge clk_sys);
            #1 lat++;
         end
      end
      if (is_snd) snd_req = 1'b0;
      else cpu_req = 1'b0;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic apply_stimulus(input logic is_snd, input logic [15:0] addr, input logic [7:0] exp_data,
                                 input int exp_lat, input string name);
      int lat;
      logic [7:0] data;
      if (is_snd) begin
         snd_req  = 1'b1;
         snd_addr = addr[13:0];
      end else begin
         cpu_req  = 1'b1;
         cpu_addr = addr;
      end
      wait_ack(is_snd, lat, data);
      check_output({name, "_lat"}, lat, exp_lat);
      check_output({name, "_data"}, data, exp_data);
   endtask

   initial begin
      int lat;
      int ack_cnt;
      logic [7:0] data;
      logic exact;
      int dl_cnt;
      int cpu_age;
      int snd_age;
      logic [15:0] wa;

      for (int i = 0; i < 65536; i++) begin
         ram[i]    = fill_val(16'(i));
         shadow[i] = fill_val(16'(i));
      end
      ram[16'h0123] = 8'hA5;  shadow[16'h0123] = 8'hA5;
      ram[16'hC010] = 8'h3C;  shadow[16'hC010] = 8'h3C;

      vecs[0] = '{1'b0, 16'h0123, 8'hA5,              "tbl_cpu_0123"};
      vecs[1] = '{1'b1, 16'hC010, 8'h3C,              "tbl_snd_c010"};
      vecs[2] = '{1'b0, 16'h4567, fill_val(16'h4567), "tbl_cpu_4567"};
      vecs[3] = '{1'b1, 16'hFFFF, fill_val(16'hFFFF), "tbl_snd_ffff"};
      vecs[4] = '{1'b0, 16'hBEEF, fill_val(16'hBEEF), "tbl_cpu_beef"};
      vecs[5] = '{1'b1, 16'hC000, fill_val(16'hC000), "tbl_snd_c000"};

      // Reset state, sampled while reset is held.
      reset = 1'b1;
      dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
      cpu_req = 1'b1; cpu_addr = 16'h5555; snd_req = 1'b0; snd_addr = '0;
      @(negedge clk_sys);
      check_output("rst_cpu_ack", cpu_ack, 0);
      check_output("rst_snd_ack", snd_ack, 0);
      check_output("rst_cpu_data", cpu_data, 0);
      check_output("rst_snd_data", snd_data, 0);
      check_output("rst_mem_we", mem_we, 0);
      check_output("rst_mem_addr", mem_addr, 0);
      check_output("rst_mem_d", mem_d, 0);

      // Table of isolated reads, each with a two-cycle latency and no writes.
      do_reset();
      we_seen = 1'b0;
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].is_snd, vecs[i].addr, vecs[i].exp_data, 2, vecs[i].name);
      end
      check_output("tbl_no_write", we_seen, 0);

      // Contention: both CPUs held high, CPU wins first, then they alternate.
      do_reset();
      cpu_req = 1'b1; cpu_addr = 16'h0123;
      snd_req = 1'b1; snd_addr = 14'h0010;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk_sys);
         check_output($sformatf("cont_both_k%0d", k), cpu_ack & snd_ack, 0);
`ifdef MCR2_ROM_ARB_CACHE_EN
         exact = (k != 3) && (k < 5);
`else
         exact = 1'b1;
`endif
         if (exact) begin
            check_output($sformatf("cont_cpu_ack_k%0d", k), cpu_ack,
                         (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 2 == 0) ? 1 : 0);
            check_output($sformatf("cont_snd_ack_k%0d", k), snd_ack,
                         (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 2 == 1) ? 1 : 0);
         end
         if (k == 2) begin
            check_output("cont_snd_mem_addr", mem_addr, 16'hC010);
            check_output("cont_cpu_data", cpu_data, 8'hA5);
         end
         if (k == 4) check_output("cont_snd_data", snd_data, 8'h3C);
         @(posedge clk_sys);
         #1;
      end

      // Download with a CPU request pending throughout.
      do_reset();
      dl_active = 1'b1;
      cpu_req = 1'b1; cpu_addr = 16'h0042;
      ack_cnt = 0;
      @(posedge clk_sys);
      #1;
      for (int i = 0; i < 256; i++) begin
         dl_wr = 1'b1; dl_addr = 16'(i); dl_data = 8'(i);
         shadow[i] = 8'(i);
         @(negedge clk_sys);
         if (cpu_ack) ack_cnt++;
         @(posedge clk_sys);
         #1;
      end
      dl_wr = 1'b0;
      dl_active = 1'b0;
      check_output("dl_no_ack", ack_cnt, 0);
      wait_ack(1'b0, lat, data);
      check_output("dl_after_lat", lat, 2);
      check_output("dl_after_data", data, 8'h42);

      // Write strobe collides with a CPU grant: write that cycle, ack at N+3.
      do_reset();
      cpu_req = 1'b1; cpu_addr = 16'h0200;
      dl_wr = 1'b1; dl_addr = 16'h0300; dl_data = 8'h77;
      shadow[16'h0300] = 8'h77;
      @(negedge clk_sys);
      check_output("coll_mem_we", mem_we, 1);
      check_output("coll_mem_addr", mem_addr, 16'h0300);
      check_output("coll_mem_d", mem_d, 8'h77);
      @(posedge clk_sys);
      #1 dl_wr = 1'b0;
      wait_ack(1'b0, lat, data);
      check_output("coll_cpu_lat", lat + 1, 3);
      check_output("coll_cpu_data", data, shadow[16'h0200]);
      apply_stimulus(1'b0, 16'h0300, 8'h77, 2, "coll_readback");

      // Reset in the middle of a sound read.
      do_reset();
      apply_stimulus(1'b1, 16'hC010, 8'h3C, 2, "rmid_pre");
      snd_req = 1'b1; snd_addr = 14'h0123;
      @(posedge clk_sys);
      #1 reset = 1'b1;
      @(negedge clk_sys);
      check_output("rmid_snd_ack", snd_ack, 0);
      check_output("rmid_snd_data", snd_data, 0);
      check_output("rmid_mem_addr", mem_addr, 0);
      check_output("rmid_mem_we", mem_we, 0);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check_output("rmid_snd_ack2", snd_ack, 0);
      @(posedge clk_sys);
      #1 reset = 1'b0;
      wait_ack(1'b1, lat, data);
      check_output("rmid_after_lat", lat, 2);
      check_output("rmid_after_data", data, shadow[16'hC123]);

`ifdef MCR2_ROM_ARB_CACHE_EN
      // Repeat read hits the tag; a download write invalidates it.
      do_reset();
      apply_stimulus(1'b0, 16'h0777, fill_val(16'h0777), 2, "cache_first");
      cpu_req = 1'b1; cpu_addr = 16'h0777;
      @(negedge clk_sys);
      check_output("cache_hit_mem_addr", mem_addr, 16'h0777);
      @(posedge clk_sys);
      #1;
      wait_ack(1'b0, lat, data);
      check_output("cache_hit_lat", lat + 1, 1);
      check_output("cache_hit_data", data, fill_val(16'h0777));
      dl_wr = 1'b1; dl_addr = 16'h0777; dl_data = 8'h99;
      shadow[16'h0777] = 8'h99;
      @(posedge clk_sys);
      #1 dl_wr = 1'b0;
      apply_stimulus(1'b0, 16'h0777, 8'h99, 2, "cache_after_wr");
`endif

      // Randomized traffic scored against the shadow memory.
      do_reset();
      dl_cnt = 0; cpu_age = 0; snd_age = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (dl_cnt == 0 && $urandom_range(0, 99) == 0) dl_cnt = 14;
         if (dl_cnt > 0) begin
            dl_active = 1'b1;
            if (dl_cnt <= 10 && dl_cnt >= 3) begin
               wa = $urandom_range(0, 1) ? (16'h1000 + 16'($urandom_range(0, 7)))
                                         : (16'hC200 + 16'($urandom_range(0, 7)));
               dl_wr = 1'b1; dl_addr = wa; dl_data = 8'($urandom);
               shadow[wa] = dl_data;
            end else begin
               dl_wr = 1'b0;
            end
            dl_cnt--;
         end else begin
            dl_active = 1'b0;
            dl_wr = 1'b0;
         end
         if (!cpu_req && $urandom_range(0, 1) == 1) begin
            cpu_req = 1'b1; cpu_addr = 16'h1000 + 16'($urandom_range(0, 7)); cpu_age = 0;
         end
         if (!snd_req && $urandom_range(0, 1) == 1) begin
            snd_req = 1'b1; snd_addr = 14'h0200 + 14'($urandom_range(0, 7)); snd_age = 0;
         end
         @(negedge clk_sys);
         check_output("rnd_ack_exclusive", cpu_ack & snd_ack, 0);
         if (cpu_ack) begin
            check_output("rnd_cpu_pending", cpu_req, 1);
            check_output("rnd_cpu_data", cpu_data, shadow[cpu_addr]);
            cpu_req = 1'b0;
         end else if (cpu_req) begin
            if (!dl_active) cpu_age++;
            if (cpu_age > 10) begin
               check_output("rnd_cpu_timeout", cpu_age, 10);
               cpu_req = 1'b0;
            end
         end
         if (snd_ack) begin
            check_output("rnd_snd_pending", snd_req, 1);
            check_output("rnd_snd_data", snd_data, shadow[{2'b11, snd_addr}]);
            snd_req = 1'b0;
         end else if (snd_req) begin
            if (!dl_active) snd_age++;
            if (snd_age > 10) begin
               check_output("rnd_snd_timeout", snd_age, 10);
               snd_req = 1'b0;
            end
         end
         @(posedge clk_sys);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
